logic_gate_pipe: RTL and testbench

//   Parametrised, pipelined multi-function bitwise logic unit. Generalises the single-bit NOT gate
//   to WIDTH-bit operands with 8 selectable gate functions. Adds STAGES register stages with

---
 rtl/logic_gate_pipe.sv | 193 +++++++++++++++++++
 tb/tb_logic_gate_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// -----------------------------------------------------------------------------
// logic_gate_pipe
//   Pipelined WIDTH-bit bitwise logic unit with eight selectable gate functions
//   (NOT, BUF, AND, OR, NAND, NOR, XOR, XNOR). The result is evaluated at the
//   input and carried with its zero and parity flags through STAGES registered
//   stages. Each stage has valid/ready flow control, so the unit can sit in
//   front of a consumer that stalls. xfer_cnt counts completed output
//   transfers.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a, b and op are valid this cycle
//   in_ready   the unit accepts an input this cycle
//   op         gate select: 0 NOT a, 1 BUF a, 2 AND, 3 OR, 4 NAND, 5 NOR,
//              6 XOR, 7 XNOR
//   a, b       operands; b is ignored by NOT and BUF
//   out_valid  y/zero/parity hold a valid result
//   out_ready  the consumer accepts the output
//   y          result
//   zero       1 when y is all zeros
//   parity     XOR reduction of y
//   xfer_cnt   number of completed output transfers; wraps, never saturates
// -----------------------------------------------------------------------------
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [15:0]      xfer_cnt
);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_BUF  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    // Selected gate function applied bitwise to the operands.
    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] opa,
        input logic [WIDTH-1:0] opb
    );
        logic [WIDTH-1:0] res;
        case (sel)
            OP_NOT:  res = ~opa;
            OP_BUF:  res = opa;
            OP_AND:  res = opa & opb;
            OP_OR:   res = opa | opb;
            OP_NAND: res = ~(opa & opb);
            OP_NOR:  res = ~(opa | opb);
            OP_XOR:  res = opa ^ opb;
            OP_XNOR: res = ~(opa ^ opb);
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Even-parity bit of a result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] val);
        return ^val;
    endfunction

    // Stage state: valid bit plus {y, zero, parity} payload per stage.
    logic [STAGES-1:0]            v_q,  v_d;
    logic [STAGES-1:0][WIDTH-1:0] y_q,  y_d;
    logic [STAGES-1:0]            z_q,  z_d;
    logic [STAGES-1:0]            p_q,  p_d;
    logic [15:0]                  cnt_q, cnt_d;

    // Upstream view of each stage (stage 0 sees the input port).
    logic [STAGES-1:0]            up_v_s;
    logic [STAGES-1:0][WIDTH-1:0] up_y_s;
    logic [STAGES-1:0]            up_z_s;
    logic [STAGES-1:0]            up_p_s;

    logic [STAGES-1:0]            rdy_s;
    logic [WIDTH-1:0]             res_s;
    logic                         out_xfer_s;

    assign res_s      = gate_eval(op, a, b);
    assign out_xfer_s = v_q[STAGES-1] & out_ready;

    // Ready chain: a stage can load when it, or any stage downstream of it,
    // holds a bubble, or when the consumer takes the output. Written as an
    // accumulated OR so no signal feeds back on itself.
    always_comb begin
        logic bubble;
        bubble = 1'b0;
        rdy_s  = {STAGES{1'b0}};
        for (int i = STAGES - 1; i >= 0; i--) begin
            bubble   = bubble | ~v_q[i];
            rdy_s[i] = bubble | out_ready;
        end
    end

    // Upstream source for every stage: the evaluated input for stage 0 and
    // the previous stage register for the rest.
    always_comb begin
        up_v_s    = {STAGES{1'b0}};
        up_y_s    = {(STAGES*WIDTH){1'b0}};
        up_z_s    = {STAGES{1'b0}};
        up_p_s    = {STAGES{1'b0}};
        up_v_s[0] = in_valid;
        up_y_s[0] = res_s;
        up_z_s[0] = (res_s == {WIDTH{1'b0}});
        up_p_s[0] = parity_of(res_s);
        for (int i = 1; i < STAGES; i++) begin
            up_v_s[i] = v_q[i-1];
            up_y_s[i] = y_q[i-1];
            up_z_s[i] = z_q[i-1];
            up_p_s[i] = p_q[i-1];
        end
    end

    // Stage next-state: a ready stage takes its upstream valid bit; the
    // payload only moves with real data, so bubbles leave it untouched and
    // y/zero/parity stay 0 after reset until the first result arrives.
    always_comb begin
        v_d = v_q;
        y_d = y_q;
        z_d = z_q;
        p_d = p_q;
        for (int i = 0; i < STAGES; i++) begin
            if (rdy_s[i]) begin
                v_d[i] = up_v_s[i];
                if (up_v_s[i]) begin
                    y_d[i] = up_y_s[i];
                    z_d[i] = up_z_s[i];
                    p_d[i] = up_p_s[i];
                end else begin
                    y_d[i] = y_q[i];
                    z_d[i] = z_q[i];
                    p_d[i] = p_q[i];
                end
            end else begin
                v_d[i] = v_q[i];
                y_d[i] = y_q[i];
                z_d[i] = z_q[i];
                p_d[i] = p_q[i];
            end
        end
    end

    // Transfer counter next-state; natural 16-bit wrap.
    always_comb begin
        if (out_xfer_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards everything in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= {STAGES{1'b0}};
            y_q   <= {(STAGES*WIDTH){1'b0}};
            z_q   <= {STAGES{1'b0}};
            p_q   <= {STAGES{1'b0}};
            cnt_q <= 16'd0;
        end else begin
            v_q   <= v_d;
            y_q   <= y_d;
            z_q   <= z_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = v_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign zero      = z_q[STAGES-1];
    assign parity    = p_q[STAGES-1];
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe (WIDTH=8, STAGES=2).
module tb_logic_gate_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [2:0]       op        = 3'd0;
    logic [WIDTH-1:0] a         = 8'h00;
    logic [WIDTH-1:0] b         = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [15:0]      xfer_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Reference gate model written from the op-code table.
    function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x;
            3'd2:    return x & z;
            3'd3:    return x | z;
            3'd4:    return ~(x & z);
            3'd5:    return ~(x | z);
            3'd6:    return x ^ z;
            default: return ~(x ^ z);
        endcase
    endfunction

    logic [7:0] exp_sweep [8];
    logic [9:0] sb_q [$];
    logic [9:0] exp_item;
    logic [7:0] r;
    int idx, run, maxrun, acc, n_out, n;

    initial begin
        exp_sweep = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};

        // ---- Reset state ----
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y",         64'(y),         64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        check("rst_parity",    64'(parity),    64'd0);
        check("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // ---- 1: NOT 0x00, latency ----
        in_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_early_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("not_y",         64'(y),         64'hFF);
        check("not_zero",      64'(zero),      64'd0);
        check("not_parity",    64'(parity),    64'd0);
        tick();
        check("not_xfer_cnt",  64'(xfer_cnt),  64'd1);
        check("not_drained",   64'(out_valid), 64'd0);

        // ---- 2: op sweep back-to-back ----
        idx = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; op = 3'(c); a = 8'hF0; b = 8'hCC;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (idx < 8) check("sweep_y", 64'(y), 64'(exp_sweep[idx]));
                idx++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("sweep_count",    64'(idx),      64'd8);
        check("sweep_run",      64'(maxrun),   64'd8);
        check("sweep_xfer_cnt", 64'(xfer_cnt), 64'd9);

        // ---- 3: stall with out_ready low ----
        do_reset();
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; op = 3'd3; a = 8'(k + 1); b = 8'h00;
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("stall_accepts",   64'(acc),       64'd2);
        check("stall_in_ready",  64'(in_ready),  64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_y",         64'(y),         64'h01);
        tick();
        check("stall_hold_y",    64'(y),         64'h01);
        out_ready = 1'b1;
        tick();
        check("stall_rel_valid", 64'(out_valid), 64'd1);
        check("stall_rel_y",     64'(y),         64'h02);
        tick();
        check("stall_empty",     64'(out_valid), 64'd0);
        check("stall_xfer_cnt",  64'(xfer_cnt),  64'd2);

        // ---- 4: reset mid-stream ----
        in_valid = 1'b1; op = 3'd1; a = 8'h55;
        tick();
        a = 8'h66;
        tick();
        in_valid = 1'b0;
        check("mid_out_valid", 64'(out_valid), 64'd1);
        check("mid_y",         64'(y),         64'h55);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_y",     64'(y),         64'd0);
        check("mid_rst_cnt",   64'(xfer_cnt),  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 64'(in_ready),  64'd1);
        tick();
        check("mid_no_stale",  64'(out_valid), 64'd0);
        tick();
        check("mid_no_stale2", 64'(out_valid), 64'd0);

        // ---- 6a: XOR a=b=A5 ----
        in_valid = 1'b1; op = 3'd6; a = 8'hA5; b = 8'hA5;
        tick();
        in_valid = 1'b0;
        tick();
        check("xor_valid",  64'(out_valid), 64'd1);
        check("xor_y",      64'(y),         64'h00);
        check("xor_zero",   64'(zero),      64'd1);
        check("xor_parity", 64'(parity),    64'd0);
        tick();
        in_valid = 1'b1; op = 3'd1; a = 8'h07;
        tick();
        in_valid = 1'b0;
        tick();
        check("buf7_y",      64'(y),        64'h07);
        check("buf7_zero",   64'(zero),     64'd0);
        check("buf7_parity", 64'(parity),   64'd1);
        tick();
        check("buf7_cnt",    64'(xfer_cnt), 64'd2);

        // ---- 6b: random handshake against scoreboard ----
        do_reset();
        n_out = 0;
        for (int c = 0; c < 1004; c++) begin
            if (c < 1000) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                op        = 3'($urandom_range(0, 7));
                a         = 8'($urandom);
                b         = 8'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            check("rnd_in_ready", 64'(in_ready), 64'((sb_q.size() < STAGES) || out_ready));
            if (out_valid && out_ready) begin
                check("rnd_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_item = sb_q.pop_front();
                    check("rnd_out", 64'({y, zero, parity}), 64'(exp_item));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                r = ref_gate(op, a, b);
                sb_q.push_back({r, (r == 8'd0), ^r});
            end
            tick();
        end
        check("rnd_drained",  64'(sb_q.size()), 64'd0);
        check("rnd_xfer_cnt", 64'(xfer_cnt),    64'(16'(n_out)));

        // ---- 5: counter wrap ----
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd1; a = 8'h3C; b = 8'h00;
        n = 0;
        for (int c = 0; c < 70000 && n < 65535; c++) begin
            #1;
            if (out_valid && out_ready) n++;
            tick();
        end
        check("wrap_transfers", 64'(n),         64'd65535);
        check("wrap_cnt_max",   64'(xfer_cnt),  64'hFFFF);
        check("wrap_valid",     64'(out_valid), 64'd1);
        tick();
        check("wrap_cnt_zero",  64'(xfer_cnt),  64'd0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
